// File: rtl/mux_select_scanner.sv
// Select driver for a 4x1 mux. It steps sel through channels 0..3, samples
// mux_out on each channel and hands the assembled word out over valid/ready.
module mux_select_scanner #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cont,
  input  logic       mux_out,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic [3:0] sample_word,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    // abort also blocks a start arriving in the same IDLE cycle
    if (abort) begin
      state_d = IDLE;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sel_d = '0;
          if (start) begin
            state_d  = SETTLE;
            cnt_d    = '0;
            shadow_d = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_MAX) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
          shadow_d[sel_q] = mux_out;
          if (sel_q != 2'd3) begin
            sel_d   = sel_q + 2'd1;
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            word_d  = {mux_out, shadow_q[2:0]};
            state_d = DONE;
          end
        end
        DONE: begin
          if (ready) begin
            sel_d = '0;
            if (cont) begin
              state_d  = SETTLE;
              cnt_d    = '0;
              shadow_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign a           = sel_q[1];
  assign b           = sel_q[0];
  assign sample_word = word_q;
  assign valid       = (state_q == DONE);
  assign busy        = (state_q == SETTLE) || (state_q == CAPTURE);

endmodule

// File: tb/tb_mux_select_scanner.sv
// Bench for mux_select_scanner: directed scenarios plus random traffic,
// checked every cycle against a schedule-based reference model.
module tb_mux_select_scanner;

  localparam int S = 2;
  localparam int P = S + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       cont;
  logic       mux_out;
  logic       ready;
  logic       a;
  logic       b;
  logic [3:0] sample_word;
  logic       valid;
  logic       busy;
  logic [3:0] i;

  int checks = 0;
  int errors = 0;

  mux_select_scanner #(
    .SETTLE_CYCLES(S),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .cont(cont),
    .mux_out(mux_out),
    .ready(ready),
    .a(a),
    .b(b),
    .sample_word(sample_word),
    .valid(valid),
    .busy(busy)
  );

  // the mux being scanned
  assign mux_out = i[{a, b}];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference: a scan is a schedule of 4*P cycles; cycle t drives
  // channel t/P and samples it when t%P == S
  bit         m_scan;
  bit         m_done;
  int         m_t;
  logic [3:0] m_acc;
  logic [3:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan = 0;
      m_done = 0;
      m_t    = 0;
      m_acc  = 0;
      m_word = 0;
    end else if (abort) begin
      m_scan = 0;
      m_done = 0;
    end else if (m_done) begin
      if (ready) begin
        m_done = 0;
        if (cont) begin
          m_scan = 1;
          m_t    = 0;
          m_acc  = 0;
        end
      end
    end else if (m_scan) begin
      if (m_t % P == S) begin
        m_acc[m_t/P] = i[m_t/P];
        if (m_t / P == 3) begin
          m_word = m_acc;
          m_scan = 0;
          m_done = 1;
        end
      end
      m_t++;
    end else if (start) begin
      m_scan = 1;
      m_t    = 0;
      m_acc  = 0;
    end
  end

  always @(negedge clk) begin
    logic [1:0] esel;
    if (rst_n) begin
      esel = m_done ? 2'd3 : (m_scan ? 2'(m_t / P) : 2'd0);
      chk("sel", {30'd0, a, b}, {30'd0, esel});
      chk("busy", {31'd0, busy}, {31'd0, m_scan});
      chk("valid", {31'd0, valid}, {31'd0, m_done});
      chk("word", {28'd0, sample_word}, {28'd0, m_word});
    end
  end

  task automatic pulse_start;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    if (!valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_sel(input logic [1:0] s);
    int n = 0;
    while ({a, b} != s && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("sel_reached", {30'd0, a, b}, {30'd0, s});
  endtask

  initial begin
    int n;
    rst_n = 0;
    start = 0;
    abort = 0;
    cont  = 0;
    ready = 0;
    i     = 4'b0101;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_ab", {30'd0, a, b}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_word", {28'd0, sample_word}, 0);

    // single scan, ready already high
    ready = 1;
    pulse_start();
    wait_valid(n);
    chk("lat_single", n, 12);
    chk("word_single", {28'd0, sample_word}, 32'h5);
    @(posedge clk);
    #1 chk("valid_one_cycle", {31'd0, valid}, 0);
    chk("idle_after", {31'd0, busy}, 0);

    // backpressure with ignored start pulses
    ready = 0;
    pulse_start();
    wait_valid(n);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = (k % 2 == 0);
      chk("bp_valid", {31'd0, valid}, 1);
      chk("bp_word", {28'd0, sample_word}, 32'h5);
      chk("bp_ab", {30'd0, a, b}, 3);
    end
    @(negedge clk);
    start = 0;
    ready = 1;
    @(posedge clk);
    #1 chk("bp_release", {31'd0, valid}, 0);
    chk("bp_idle", {31'd0, busy}, 0);

    // continuous mode, mux inputs change for the second scan
    cont = 1;
    pulse_start();
    wait_valid(n);
    chk("cont_w1", {28'd0, sample_word}, 32'h5);
    i = 4'b1010;
    @(posedge clk);
    #1 chk("cont_restart", {31'd0, busy}, 1);
    chk("cont_sel0", {30'd0, a, b}, 0);
    cont = 0;
    wait_valid(n);
    chk("cont_lat", n, 12);
    chk("cont_w2", {28'd0, sample_word}, 32'hA);
    @(posedge clk);
    #1 chk("cont_end", {31'd0, busy | valid}, 0);

    // abort on channel 2
    i = 4'b0101;
    pulse_start();
    wait_sel(2'd2);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    chk("abort_ab", {30'd0, a, b}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_valid", {31'd0, valid}, 0);
    chk("abort_word", {28'd0, sample_word}, 32'hA);
    i = 4'b0110;
    pulse_start();
    wait_valid(n);
    chk("post_abort_lat", n, 12);
    chk("post_abort_word", {28'd0, sample_word}, 32'h6);
    @(posedge clk);

    // async reset during channel 1
    i = 4'b1001;
    pulse_start();
    wait_sel(2'd1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_ab", {30'd0, a, b}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_word", {28'd0, sample_word}, 0);
    @(negedge clk);
    rst_n = 1;
    pulse_start();
    chk("arst_ch0", {30'd0, a, b}, 0);
    wait_valid(n);
    chk("arst_lat", n, 12);
    chk("arst_word2", {28'd0, sample_word}, 32'h9);

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 40) == 0);
      ready = $urandom_range(0, 1) != 0;
      cont  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) i = 4'($urandom);
    end
    @(negedge clk);
    start = 0;
    abort = 0;
    cont  = 0;
    ready = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
